// File: rtl/main_mem_line_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// main_mem_line_ctrl_pkg
//   Shared constants and types for the main-memory line controller.
//   Holds the cache-line geometry and the word width of the backing memory.
//   It also holds the controller state encoding.
//
//   Contents
//     BYTES_PER_LINE    line size in bytes
//     MAIN_MEM_LINE_AW  line address width
//     LINE_W            line width in bits
//     WORD_W            default backing-memory word width
//     WORDS_PER_LINE    beats per line at the default word width
//     mm_state_t        controller states IDLE / WR / RD / ACK
// -----------------------------------------------------------------------------
package main_mem_line_ctrl_pkg;

    localparam int BYTES_PER_LINE   = 16;
    localparam int MAIN_MEM_LINE_AW = 10;
    localparam int LINE_W           = BYTES_PER_LINE * 8;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } mm_state_t;

endpackage : main_mem_line_ctrl_pkg

// File: rtl/main_mem_line_ctrl.sv
// -----------------------------------------------------------------------------
// main_mem_line_ctrl
//   Takes the single granted line request from the main-memory arbiter. It
//   serialises a cache-line write and/or read into WORD_W-wide beats on a word
//   memory port. It returns the assembled read line on rdata_o. One ack_o pulse
//   completes each request. When a write and a read arrive together (eviction
//   plus fill), the full write is issued before the first read beat.
//
//   Ports
//     clk           clock
//     reset         synchronous, active-high reset
//     wcyc_i        line write request
//     rcyc_i        line read request
//     waddr_i       write line address
//     raddr_i       read line address
//     wdata_i       write line data (word 0 in the LSBs)
//     ack_o         one-cycle completion pulse back to the arbiter
//     rdata_o       assembled read line, valid from ack_o until the next accept
//     mem_req_o     word access request
//     mem_we_o      1 = write beat, 0 = read beat
//     mem_addr_o    word address {line_addr, beat}
//     mem_wdata_o   write word
//     mem_ready_i   beat accepted when mem_req_o & mem_ready_i
//     mem_rvalid_i  read word returned (in order, at least one cycle after accept)
//     mem_rdata_i   read word
// -----------------------------------------------------------------------------
module main_mem_line_ctrl
    import main_mem_line_ctrl_pkg::*;
#(
    parameter int WORD_W = main_mem_line_ctrl_pkg::WORD_W
) (
    input  logic                                  clk,
    input  logic                                  reset,

    input  logic                                  wcyc_i,
    input  logic                                  rcyc_i,
    input  logic [MAIN_MEM_LINE_AW-1:0]           waddr_i,
    input  logic [MAIN_MEM_LINE_AW-1:0]           raddr_i,
    input  logic [LINE_W-1:0]                     wdata_i,
    output logic                                  ack_o,
    output logic [LINE_W-1:0]                     rdata_o,

    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [MAIN_MEM_LINE_AW+$clog2(LINE_W/WORD_W)-1:0] mem_addr_o,
    output logic [WORD_W-1:0]                     mem_wdata_o,
    input  logic                                  mem_ready_i,
    input  logic                                  mem_rvalid_i,
    input  logic [WORD_W-1:0]                     mem_rdata_i
);

    localparam int N  = LINE_W / WORD_W;
    localparam int BW = $clog2(N);
    localparam int CW = BW + 1;
    localparam int AW = MAIN_MEM_LINE_AW;

    // Counters carry one extra bit so "all N beats done" is representable
    // without wrapping back to zero.
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef logic [N-1:0][WORD_W-1:0] line_words_t;

    mm_state_t   state_q,   state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    line_words_t wdata_q,   wdata_d;
    line_words_t rdata_q,   rdata_d;
    logic        pend_rd_q, pend_rd_d;
    logic [CW-1:0] wr_cnt_q,  wr_cnt_d;   // write beats accepted
    logic [CW-1:0] iss_cnt_q, iss_cnt_d;  // read beats accepted
    logic [CW-1:0] rcv_cnt_q, rcv_cnt_d;  // read words received

    assign rdata_o = rdata_q;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned; an unassigned path would infer a latch.
        state_d     = state_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        pend_rd_d   = pend_rd_q;
        wr_cnt_d    = wr_cnt_q;
        iss_cnt_d   = iss_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;

        ack_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                if (wcyc_i || rcyc_i) begin
                    // The request is latched here, so the arbiter may change
                    // its inputs freely once the transfer is under way.
                    waddr_d   = waddr_i;
                    raddr_d   = raddr_i;
                    wdata_d   = wdata_i;
                    pend_rd_d = rcyc_i;
                    wr_cnt_d  = '0;
                    iss_cnt_d = '0;
                    rcv_cnt_d = '0;
                    state_d   = wcyc_i ? WR : RD;
                end
            end

            WR: begin
                // Address and data depend only on registered state. They
                // therefore hold steady while mem_ready_i stalls the beat.
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {waddr_q, wr_cnt_q[BW-1:0]};
                mem_wdata_o = wdata_q[wr_cnt_q[BW-1:0]];
                if (mem_ready_i) begin
                    wr_cnt_d = wr_cnt_q + ONE_C;
                    if (wr_cnt_q == LAST_C) begin
                        state_d = pend_rd_q ? RD : ACK;
                    end
                end
            end

            RD: begin
                // Issue and receive run independently. Beats keep issuing
                // while earlier words are still in flight.
                if (iss_cnt_q < N_C) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {raddr_q, iss_cnt_q[BW-1:0]};
                    if (mem_ready_i) begin
                        iss_cnt_d = iss_cnt_q + ONE_C;
                    end
                end
                if (mem_rvalid_i && (rcv_cnt_q < N_C)) begin
                    rdata_d[rcv_cnt_q[BW-1:0]] = mem_rdata_i;
                    rcv_cnt_d = rcv_cnt_q + ONE_C;
                    if (rcv_cnt_q == LAST_C) begin
                        state_d = ACK;
                    end
                end
            end

            ACK: begin
                ack_o   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from the values the combinational block computed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            raddr_q   <= '0;
            wdata_q   <= '0;
            // NOTE: the read line buffer is cleared on reset even though it is
            // storage. After reset, rdata_o must read as zero rather than
            // return the line of an abandoned transfer.
            rdata_q   <= '0;
            pend_rd_q <= 1'b0;
            wr_cnt_q  <= '0;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            pend_rd_q <= pend_rd_d;
            wr_cnt_q  <= wr_cnt_d;
            iss_cnt_q <= iss_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
        end
    end

endmodule : main_mem_line_ctrl

// File: tb/tb_main_mem_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_main_mem_line_ctrl
//   Self-checking bench for main_mem_line_ctrl. A word-memory responder
//   supplies ready and in-order read data with a programmable latency. It logs
//   every accepted beat. Each scenario task compares that log, ack timing and
//   rdata_o against expectations derived from the line-level request.
// -----------------------------------------------------------------------------
module tb_main_mem_line_ctrl;
    import main_mem_line_ctrl_pkg::*;

    localparam int W         = 32;
    localparam int N         = LINE_W / W;
    localparam int BW        = $clog2(N);
    localparam int AW        = MAIN_MEM_LINE_AW;
    localparam int MAW       = AW + BW;
    localparam int MEM_WORDS = 1 << MAW;

    logic              clk = 1'b0;
    logic              reset;
    logic              wcyc_i, rcyc_i;
    logic [AW-1:0]     waddr_i, raddr_i;
    logic [LINE_W-1:0] wdata_i;
    logic              ack_o;
    logic [LINE_W-1:0] rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [MAW-1:0]    mem_addr_o;
    logic [W-1:0]      mem_wdata_o;
    logic              mem_ready_i, mem_rvalid_i;
    logic [W-1:0]      mem_rdata_i;

    always #5 clk = ~clk;

    main_mem_line_ctrl #(.WORD_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wcyc_i       (wcyc_i),
        .rcyc_i       (rcyc_i),
        .waddr_i      (waddr_i),
        .raddr_i      (raddr_i),
        .wdata_i      (wdata_i),
        .ack_o        (ack_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    typedef struct {
        bit             we;
        logic [MAW-1:0] addr;
        logic [W-1:0]   data;
    } beat_t;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } resp_t;

    logic [W-1:0]      mem [0:MEM_WORDS-1];
    beat_t             blog[$];
    resp_t             rq[$];
    int                ready_mode;   // 0 always ready, 1 random, 2 pattern 1,0,0
    int                pat_idx;
    int                rd_lat;
    int                cyc_n;
    bit                stray_rv;
    int                n_cmp;
    int                n_bad;
    logic [LINE_W-1:0] exp_rdata;

    // -------------------------------------------------------------------------
    // Word-memory responder: drives inputs on the falling edge, then predicts
    // the beat that the next rising edge will accept.
    // -------------------------------------------------------------------------
    initial begin : responder
        bit             stall_prev;
        logic [MAW-1:0] prev_addr;
        logic [W-1:0]   prev_wdata;
        logic           prev_we;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        stall_prev   = 1'b0;
        prev_addr    = '0;
        prev_wdata   = '0;
        prev_we      = 1'b0;
        forever begin
            @(negedge clk);
            cyc_n++;
            case (ready_mode)
                1:       mem_ready_i = 1'($urandom_range(0, 1));
                2:       mem_ready_i = ((pat_idx % 3) == 0);
                default: mem_ready_i = 1'b1;
            endcase
            pat_idx++;
            if (rq.size() > 0 && rq[0].due <= cyc_n) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rq[0].data;
                void'(rq.pop_front());
            end else begin
                mem_rvalid_i = stray_rv;
                mem_rdata_i  = $urandom;
            end
            #1;
            if (stall_prev) begin
                n_cmp++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr || mem_we_o !== prev_we ||
                    (prev_we && mem_wdata_o !== prev_wdata)) begin
                    n_bad++;
                    $display("FAIL stall_hold: got req=%b we=%b addr=%h data=%h, expected req=1 we=%b addr=%h data=%h",
                             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, prev_we, prev_addr, prev_wdata);
                end
            end
            stall_prev = mem_req_o && !mem_ready_i && !reset;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;
            prev_we    = mem_we_o;
            if (mem_req_o && mem_ready_i) begin
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                    blog.push_back('{we: 1'b1, addr: mem_addr_o, data: mem_wdata_o});
                end else begin
                    rq.push_back('{due: cyc_n + rd_lat, data: mem[mem_addr_o]});
                    blog.push_back('{we: 1'b0, addr: mem_addr_o, data: '0});
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        wcyc_i = 1'b0;
        rcyc_i = 1'b0;
        step();
        reset = 1'b0;
        exp_rdata = '0;
    endtask

    // One line transfer from an idle controller, with all checks inline.
    task automatic do_xfer(input bit w, input bit r, input logic [AW-1:0] wa,
                           input logic [AW-1:0] ra, input logic [LINE_W-1:0] wd,
                           input int lat_exp, input string name);
        beat_t             exp_q[$];
        logic [LINE_W-1:0] old_line;
        int                lat;
        bit                got;
        bit                extra;
        for (int i = 0; i < N; i++) old_line[i*W +: W] = mem[{ra, BW'(i)}];
        if (w) for (int i = 0; i < N; i++)
            exp_q.push_back('{we: 1'b1, addr: {wa, BW'(i)}, data: wd[i*W +: W]});
        if (r) for (int i = 0; i < N; i++)
            exp_q.push_back('{we: 1'b0, addr: {ra, BW'(i)}, data: '0});
        blog.delete();

        wcyc_i  = w;
        rcyc_i  = r;
        waddr_i = wa;
        raddr_i = ra;
        wdata_i = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            step();
            lat++;
            if (ack_o === 1'b1) got = 1'b1;
        end
        wcyc_i = 1'b0;
        rcyc_i = 1'b0;

        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s ack_timeout: got no ack in %0d cycles, expected an ack", name, lat);
            pulse_reset();
            return;
        end
        if (lat_exp >= 0) begin
            n_cmp++;
            if (lat != lat_exp) begin
                n_bad++;
                $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, lat_exp);
            end
        end
        if (r) exp_rdata = (w && wa == ra) ? wd : old_line;
        n_cmp++;
        if (rdata_o !== exp_rdata) begin
            n_bad++;
            $display("FAIL %s rdata: got %h expected %h", name, rdata_o, exp_rdata);
        end

        step();
        n_cmp++;
        if (ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ack_width: got ack=%b one cycle later, expected 0", name, ack_o);
        end
        extra = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ack_o !== 1'b0 || mem_req_o !== 1'b0) extra = 1'b1;
        end
        n_cmp++;
        if (extra) begin
            n_bad++;
            $display("FAIL %s idle_after_ack: got extra ack or request, expected quiet bus", name);
        end

        n_cmp++;
        if (blog.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s beat_count: got %0d beats, expected %0d", name, blog.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < blog.size(); i++) begin
            n_cmp++;
            if (blog[i].we !== exp_q[i].we || blog[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && blog[i].data !== exp_q[i].data)) begin
                n_bad++;
                $display("FAIL %s beat%0d: got we=%b addr=%h data=%h, expected we=%b addr=%h data=%h",
                         name, i, blog[i].we, blog[i].addr, blog[i].data,
                         exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < N; i++) l[i*W +: W] = $urandom;
        return l;
    endfunction

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || rdata_o !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b req=%b we=%b rdata=%h, expected all 0",
                     ack_o, mem_req_o, mem_we_o, rdata_o);
        end
        reset = 1'b0;
        exp_rdata = '0;
        step();
        step();
        n_cmp++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got ack=%b req=%b, expected 0 0", ack_o, mem_req_o);
        end
    endtask

    task automatic test_write_line();
        ready_mode = 0;
        rd_lat = 2;
        do_xfer(1'b1, 1'b0, AW'(12'h012), AW'(12'h000),
                {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011},
                N + 1, "write_line");
    endtask

    task automatic test_read_line();
        ready_mode = 0;
        rd_lat = 2;
        for (int i = 0; i < N; i++) mem[{AW'(12'h005), BW'(i)}] = 32'h0000_00A0 + i;
        do_xfer(1'b0, 1'b1, AW'(12'h000), AW'(12'h005), '0, N + 2 + 1, "read_line");
    endtask

    task automatic test_evict_fill();
        ready_mode = 0;
        rd_lat = 2;
        do_xfer(1'b1, 1'b1, AW'(12'h001), AW'(12'h002), rand_line(), 2 * N + 2 + 1, "evict_fill");
    endtask

    task automatic test_write_stall();
        ready_mode = 2;
        pat_idx = 0;
        do_xfer(1'b1, 1'b0, AW'($urandom), AW'(12'h000), rand_line(), -1, "write_stall");
        ready_mode = 0;
    endtask

    task automatic test_reset_mid_read();
        int n;
        int nrd;
        ready_mode = 0;
        rd_lat = 2;
        blog.delete();
        raddr_i = AW'(12'h033);
        rcyc_i = 1'b1;
        n = 0;
        nrd = 0;
        while (nrd < 2 && n < 50) begin
            step();
            n++;
            nrd = 0;
            foreach (blog[i]) if (!blog[i].we) nrd++;
        end
        n_cmp++;
        if (nrd < 2) begin
            n_bad++;
            $display("FAIL midrd_issue: got %0d read beats, expected at least 2", nrd);
        end
        reset = 1'b1;
        rcyc_i = 1'b0;
        step();
        reset = 1'b0;
        exp_rdata = '0;
        n_cmp++;
        if (mem_req_o !== 1'b0 || rdata_o !== '0 || ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL midrd_reset: got req=%b ack=%b rdata=%h, expected 0 0 0",
                     mem_req_o, ack_o, rdata_o);
        end
        stray_rv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (mem_req_o !== 1'b0 || ack_o !== 1'b0 || rdata_o !== '0) begin
                n_bad++;
                $display("FAIL midrd_stray%0d: got req=%b ack=%b rdata=%h, expected 0 0 0",
                         i, mem_req_o, ack_o, rdata_o);
            end
        end
        stray_rv = 1'b0;
        step();
        do_xfer(1'b0, 1'b1, AW'(12'h000), AW'(12'h034), '0, N + 2 + 1, "midrd_recover");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]     wa1, wa2;
        logic [LINE_W-1:0] wd1, wd2;
        int                lat;
        bit                got;
        ready_mode = 0;
        wa1 = AW'($urandom);
        wa2 = wa1 + AW'(7);
        wd1 = rand_line();
        wd2 = rand_line();
        blog.delete();
        wcyc_i = 1'b1;
        rcyc_i = 1'b0;
        waddr_i = wa1;
        wdata_i = wd1;
        for (int t = 0; t < 2; t++) begin
            lat = 0;
            got = 1'b0;
            while (!got && lat < 300) begin
                step();
                lat++;
                if (ack_o === 1'b1) got = 1'b1;
            end
            n_cmp++;
            // The second transfer waits one IDLE cycle after ACK before it is accepted.
            if (!got || lat != N + 1 + t) begin
                n_bad++;
                $display("FAIL b2b_ack%0d: got ack=%b after %0d cycles, expected ack after %0d",
                         t, got, lat, N + 1 + t);
            end
            waddr_i = wa2;
            wdata_i = wd2;
        end
        wcyc_i = 1'b0;
        step();
        step();
        n_cmp++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got ack=%b req=%b, expected 0 0", ack_o, mem_req_o);
        end
        n_cmp++;
        if (blog.size() != 2 * N) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d beats, expected %0d", blog.size(), 2 * N);
        end
        for (int i = 0; i < 2 * N && i < blog.size(); i++) begin
            logic [AW-1:0] la;
            logic [W-1:0]  ed;
            la = (i < N) ? wa1 : wa2;
            ed = (i < N) ? wd1[(i % N)*W +: W] : wd2[(i % N)*W +: W];
            n_cmp++;
            if (blog[i].we !== 1'b1 || blog[i].addr !== {la, BW'(i % N)} || blog[i].data !== ed) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                         i, blog[i].we, blog[i].addr, blog[i].data, {la, BW'(i % N)}, ed);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            bit            w, r;
            int            kind;
            int            le;
            logic [AW-1:0] wa, ra;
            kind = $urandom_range(0, 2);
            w = (kind != 1);
            r = (kind != 0);
            wa = AW'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            ready_mode = $urandom_range(0, 1);
            rd_lat = $urandom_range(1, 3);
            if (ready_mode != 0) le = -1;
            else if (w && r) le = 2 * N + rd_lat + 1;
            else if (w)      le = N + 1;
            else             le = N + rd_lat + 1;
            do_xfer(w, r, wa, ra, rand_line(), le, $sformatf("rand%0d", k));
        end
        ready_mode = 0;
        rd_lat = 2;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ready_mode = 0;
        pat_idx = 0;
        rd_lat = 2;
        cyc_n = 0;
        stray_rv = 1'b0;
        exp_rdata = '0;
        reset = 1'b1;
        wcyc_i = 1'b0;
        rcyc_i = 1'b0;
        waddr_i = '0;
        raddr_i = '0;
        wdata_i = '0;

        test_reset();
        test_write_line();
        test_read_line();
        test_evict_fill();
        test_write_stall();
        test_reset_mid_read();
        test_back_to_back();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_main_mem_line_ctrl
